// File: rtl/rcvr_pkg.sv
// Shared types and defaults for the rcvr serial frame receiver.
package rcvr_pkg;

  typedef enum logic {
    HUNT,
    PAYLOAD
  } state_t;

  localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;
  localparam int unsigned DEFAULT_NBYTES = 2;

endpackage

// File: rtl/rcvr_outbuf.sv
// Byte-wide output buffer for rcvr: frame commit, READY/ACK pop, overflow discard.
// Define RCVR_OVERFLOW_EN to add the sticky overflow flag output.
module rcvr_outbuf
  import rcvr_pkg::*;
#(
  parameter int unsigned NBYTES = DEFAULT_NBYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                commit,
  input  logic [8*NBYTES-1:0] data,
  input  logic                ack,
  output logic                ready,
  output logic [7:0]          dout
`ifdef RCVR_OVERFLOW_EN
  ,
  output logic                overflow
`endif
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES + 1);

  logic [W-1:0]  data_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  shifted;
  logic          pop;
  logic          load;
  logic          drop;

  always_comb begin
    pop     = ack && ready;
    load    = commit && (count_q == '0);
    drop    = commit && (count_q != '0);
    shifted = data_q << 8;
  end

  // ready mirrors (count_q != 0), so load and pop never coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      ready   <= 1'b0;
      dout    <= '0;
    end else if (load) begin
      data_q  <= data;
      count_q <= CW'(NBYTES);
      ready   <= 1'b1;
      dout    <= data[W-1 -: 8];
    end else if (pop) begin
      data_q  <= shifted;
      count_q <= count_q - CW'(1);
      ready   <= (count_q != CW'(1));
      if (count_q != CW'(1))
        dout <= shifted[W-1 -: 8];
    end
  end

`ifdef RCVR_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: rtl/rcvr.sv
// Serial frame receiver: hunts for HEADER, captures 8*NBYTES payload bits MSB first.
// Define RCVR_OVERFLOW_EN to expose the sticky OVERFLOW output.
module rcvr
  import rcvr_pkg::*;
#(
  parameter logic [7:0]  HEADER = DEFAULT_HEADER,
  parameter int unsigned NBYTES = DEFAULT_NBYTES
) (
  input  logic       SCLK,
  input  logic       RST,
  input  logic       SDATA,
  input  logic       ACK,
  output logic       READY,
  output logic [7:0] DOUT
`ifdef RCVR_OVERFLOW_EN
  ,
  output logic       OVERFLOW
`endif
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned BW = $clog2(W);

  state_t        state;
  logic [7:0]    window;
  logic [W-1:0]  payload;
  logic [BW-1:0] bit_cnt;
  logic          commit;
  logic [W-1:0]  frame;
  logic [7:0]    window_next;

  // The completed frame includes the bit sampled on the commit edge itself.
  always_comb begin
    commit      = (state == PAYLOAD) && (bit_cnt == BW'(W - 1));
    frame       = {payload[W-2:0], SDATA};
    window_next = {window[6:0], SDATA};
  end

  always_ff @(posedge SCLK) begin
    if (!RST) begin
      state   <= HUNT;
      window  <= '0;
      payload <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        HUNT: begin
          window <= window_next;
          if (window_next == HEADER) begin
            state   <= PAYLOAD;
            bit_cnt <= '0;
          end
        end
        PAYLOAD: begin
          payload <= frame;
          bit_cnt <= bit_cnt + BW'(1);
          if (commit) begin
            state   <= HUNT;
            window  <= '0;
            bit_cnt <= '0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  rcvr_outbuf #(
    .NBYTES(NBYTES)
  ) u_outbuf (
    .clk     (SCLK),
    .rst_n   (RST),
    .commit  (commit),
    .data    (frame),
    .ack     (ACK),
    .ready   (READY),
    .dout    (DOUT)
`ifdef RCVR_OVERFLOW_EN
    ,
    .overflow(OVERFLOW)
`endif
  );

endmodule

// File: tb/tb_rcvr.sv
// Self-checking bench for rcvr: frame table plus hand sequences, byte scoreboard on ACK pops.
// Checks OVERFLOW as well when RCVR_OVERFLOW_EN is defined.
module tb_rcvr;

  logic       SCLK  = 1'b0;
  logic       RST   = 1'b0;
  logic       SDATA = 1'b0;
  logic       ACK   = 1'b0;
  logic       READY;
  logic [7:0] DOUT;
`ifdef RCVR_OVERFLOW_EN
  logic       OVERFLOW;
`endif

  rcvr #(
    .HEADER(8'hA5),
    .NBYTES(2)
  ) dut (
    .SCLK (SCLK),
    .RST  (RST),
    .SDATA(SDATA),
    .ACK  (ACK),
    .READY(READY),
    .DOUT (DOUT)
`ifdef RCVR_OVERFLOW_EN
    ,
    .OVERFLOW(OVERFLOW)
`endif
  );

  always #5 SCLK = ~SCLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_q[$];

  typedef struct {
    logic [7:0]  hdr;
    logic [15:0] pay;
    logic        accept;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // One cycle: drive inputs, let the edge happen, score any byte popped at that edge.
  task automatic tick(input logic sd, input logic ack);
    logic       pre_ready;
    logic [7:0] pre_dout;
    SDATA     = sd;
    ACK       = ack;
    pre_ready = READY;
    pre_dout  = DOUT;
    @(posedge SCLK);
    #1;
    if (ack && pre_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got byte %0h, required no byte", pre_dout);
      end else begin
        check("pop_byte", 32'(pre_dout), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic idle(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0);
      if (READY !== 1'b0) seen = 1'b1;
    end
  endtask

  task automatic send_word(input logic [15:0] v, input int nbits, input logic ack_last);
    for (int i = nbits - 1; i >= 0; i--)
      tick(v[i], ack_last && (i == 0));
  endtask

  task automatic drain2(input logic [15:0] pay);
    tick(1'b0, 1'b1);
    check("dout_second", 32'(DOUT), 32'(pay[7:0]));
    check("ready_mid", 32'(READY), 32'd1);
    tick(1'b0, 1'b1);
    check("ready_drained", 32'(READY), 32'd0);
    check("dout_hold", 32'(DOUT), 32'(pay[7:0]));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic good_frame(input logic [15:0] pay, input logic ack_last);
    logic seen;
    idle(32, seen);
    check("preamble_ready", 32'(seen), 32'd0);
    send_word(16'h00A5, 8, 1'b0);
    exp_q.push_back(pay[15:8]);
    exp_q.push_back(pay[7:0]);
    send_word(pay, 16, ack_last);
    check("ready_after_frame", 32'(READY), 32'd1);
    check("dout_head", 32'(DOUT), 32'(pay[15:8]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic bad;

    vecs[0] = '{hdr: 8'hA5, pay: 16'h1234, accept: 1'b1};
    for (int i = 1; i <= 4; i++)
      vecs[i] = '{hdr: 8'hA5, pay: 16'($urandom), accept: 1'b1};
    vecs[5] = '{hdr: 8'hA4, pay: 16'hFFFF, accept: 1'b0};
    vecs[6] = '{hdr: 8'hA5, pay: 16'hA5A5, accept: 1'b1};

    // Reset, then idle
    RST = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("reset_ready", 32'(READY), 32'd0);
    check("reset_dout", 32'(DOUT), 32'd0);
`ifdef RCVR_OVERFLOW_EN
    check("reset_overflow", 32'(OVERFLOW), 32'd0);
`endif
    RST = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0);
      if (READY !== 1'b0 || DOUT !== 8'h00) bad = 1'b1;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Table of frames
    for (int v = 0; v < 7; v++) begin
      idle(32, seen);
      check("preamble_ready", 32'(seen), 32'd0);
      send_word(16'(vecs[v].hdr), 8, 1'b0);
      if (vecs[v].accept) begin
        exp_q.push_back(vecs[v].pay[15:8]);
        exp_q.push_back(vecs[v].pay[7:0]);
      end
      send_word(vecs[v].pay, 16, 1'b0);
      check("ready_after_frame", 32'(READY), 32'(vecs[v].accept));
      if (vecs[v].accept) begin
        check("dout_head", 32'(DOUT), 32'(vecs[v].pay[15:8]));
        drain2(vecs[v].pay);
      end else begin
        idle(24, seen);
        check("near_miss_quiet", 32'(seen), 32'd0);
      end
    end
    idle(40, seen);
    check("no_retrigger", 32'(seen), 32'd0);

    // Overflow: second frame arrives while first is unread
    good_frame(16'hBEEF, 1'b0);
`ifdef RCVR_OVERFLOW_EN
    check("overflow_before", 32'(OVERFLOW), 32'd0);
`endif
    for (int i = 0; i < 32; i++) tick(1'b0, 1'b0);
    send_word(16'h00A5, 8, 1'b0);
    send_word(16'h1111, 16, 1'b0);
    check("ovf_ready", 32'(READY), 32'd1);
    check("ovf_dout", 32'(DOUT), 32'h0BE);
`ifdef RCVR_OVERFLOW_EN
    check("overflow_after", 32'(OVERFLOW), 32'd1);
`endif
    drain2(16'hBEEF);

    // Commit into empty buffer with ACK on the same edge: ACK ignored
    good_frame(16'h5A3C, 1'b1);
    drain2(16'h5A3C);

    // Reset mid-payload, then a fresh frame
    for (int i = 0; i < 32; i++) tick(1'b0, 1'b0);
    send_word(16'h00A5, 8, 1'b0);
    send_word(16'h0077, 8, 1'b0);
    RST = 1'b0;
    tick(1'b0, 1'b0);
    RST = 1'b1;
    check("midreset_ready", 32'(READY), 32'd0);
`ifdef RCVR_OVERFLOW_EN
    check("midreset_overflow", 32'(OVERFLOW), 32'd0);
`endif
    good_frame(16'hCAFE, 1'b0);
    drain2(16'hCAFE);
    idle(40, seen);
    check("final_quiet", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
